// File: rtl/tl_ul_ram_responder_if.sv
// TL-UL A/D channel bundle between one requester (master) and one
// responder (slave). Handshake: a beat moves on a channel at a rising clock
// edge where that channel's valid and ready are both 1. The sender holds the
// payload stable while valid=1 and ready=0. A sender never withdraws valid
// before the beat moves, and ready may depend combinationally on state only.
interface tl_ul_ram_responder_if #(
  parameter int ADDR_WIDTH   = 9,
  parameter int SOURCE_WIDTH = 2
);
  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [2:0]              a_param;
  logic [1:0]              a_size;
  logic [SOURCE_WIDTH-1:0] a_source;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [3:0]              a_mask;
  logic [31:0]             a_data;
  logic                    a_corrupt;

  logic                    d_valid;
  logic                    d_ready;
  logic [2:0]              d_opcode;
  logic [1:0]              d_param;
  logic [1:0]              d_size;
  logic [SOURCE_WIDTH-1:0] d_source;
  logic                    d_sink;
  logic                    d_denied;
  logic [31:0]             d_data;
  logic                    d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask,
           a_data, a_corrupt, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink,
           d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_ram_responder.sv
// TL-UL responder in front of a 32-bit flop RAM. Legal Get/PutFull/
// PutPartial requests access the RAM; anything else is answered with a
// denied response. Responses leave in request order through a 2-entry queue
// whose head registers drive the D channel directly.
module tl_ul_ram_responder #(
  parameter int ADDR_WIDTH   = 9,
  parameter int SOURCE_WIDTH = 2
) (
  input  logic clock,
  input  logic reset,
  tl_ul_ram_responder_if.slave tl
);
  localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

  typedef struct packed {
    logic [2:0]              opcode;
    logic [1:0]              size;
    logic [SOURCE_WIDTH-1:0] source;
    logic                    denied;
    logic [31:0]             data;
    logic                    corrupt;
  } rsp_t;

  rsp_t                  q0, q1, rsp_new;
  logic [1:0]            count;
  logic [3:0]            em;
  logic                  misaligned, op_legal, is_get, denied;
  logic                  a_fire, d_fire, ram_we;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [31:0]           mem [DEPTH];

  assign word_idx    = tl.a_address[ADDR_WIDTH-1:2];
  assign tl.a_ready  = (count != 2'd2);
  assign tl.d_valid  = (count != 2'd0);
  // A beat offered during reset is neither accepted nor written.
  assign a_fire      = tl.a_valid & tl.a_ready & ~reset;
  assign d_fire      = tl.d_valid & tl.d_ready;

  // Expected byte lanes for the requested size and low address bits.
  always_comb begin
    em = 4'h0;
    case (tl.a_size)
      2'd0:    em = 4'b0001 << tl.a_address[1:0];
      2'd1:    em = tl.a_address[1] ? 4'b1100 : 4'b0011;
      2'd2:    em = 4'hF;
      default: em = 4'h0;
    endcase
  end

  // Legality of the presented request and the response it will produce.
  always_comb begin
    misaligned = ((tl.a_size == 2'd1) && tl.a_address[0]) ||
                 ((tl.a_size == 2'd2) && (tl.a_address[1:0] != 2'd0));
    op_legal   = (tl.a_opcode == 3'd0) || (tl.a_opcode == 3'd1) ||
                 (tl.a_opcode == 3'd4);
    is_get     = (tl.a_opcode == 3'd4);
    denied     = !op_legal || (tl.a_param != 3'd0) || (tl.a_size == 2'd3) ||
                 misaligned ||
                 ((tl.a_opcode == 3'd0) && (tl.a_mask != em)) ||
                 ((tl.a_opcode == 3'd1) && ((tl.a_mask & ~em) != 4'h0));

    rsp_new        = '0;
    rsp_new.size   = tl.a_size;
    rsp_new.source = tl.a_source;
    rsp_new.opcode = is_get ? 3'd1 : 3'd0;
    if (denied) begin
      rsp_new.denied  = 1'b1;
      // Only a data-carrying response can flag its (absent) data as bad.
      rsp_new.corrupt = is_get;
    end else if (is_get) begin
      // Whole word is returned whatever the size; the requester picks lanes.
      rsp_new.data = mem[word_idx];
    end
  end

  // A poisoned Put is acknowledged normally but leaves the RAM untouched.
  assign ram_we = a_fire && !denied && !is_get && !tl.a_corrupt;

  // Byte-masked RAM write; the array is deliberately never reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (tl.a_mask[b]) mem[word_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
      end
    end
  end

  // Two-entry in-order response queue; q0 is always the head.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= 2'd0;
      q0    <= '0;
      q1    <= '0;
    end else begin
      case ({a_fire, d_fire})
        2'b10: begin
          if (count == 2'd0) q0 <= rsp_new;
          else               q1 <= rsp_new;
          count <= count + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q1    <= '0;
          count <= count - 2'd1;
        end
        // Simultaneous enqueue/dequeue only happens with one entry held.
        2'b11: q0 <= rsp_new;
        default: ;
      endcase
    end
  end

  assign tl.d_opcode  = q0.opcode;
  assign tl.d_param   = 2'd0;
  assign tl.d_size    = q0.size;
  assign tl.d_source  = q0.source;
  assign tl.d_sink    = 1'b0;
  assign tl.d_denied  = q0.denied;
  assign tl.d_data    = q0.data;
  assign tl.d_corrupt = q0.corrupt;
endmodule

// File: tb/tb_tl_ul_ram_responder.sv
// Directed bench for tl_ul_ram_responder: requests are driven from tasks,
// each accepted request pushes its hand-computed response into exp_q, and a
// negedge monitor compares every D-channel beat against the queue head.
module tb_tl_ul_ram_responder;
  localparam int W = 44;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic third_done;

  tl_ul_ram_responder_if #(.ADDR_WIDTH(9), .SOURCE_WIDTH(2)) tl ();

  tl_ul_ram_responder #(.ADDR_WIDTH(9), .SOURCE_WIDTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .tl    (tl)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rsp(input logic [2:0] op, input logic [1:0] size,
                                       input logic [1:0] src, input logic den,
                                       input logic [31:0] data, input logic cor);
    return {op, 2'b00, size, src, 1'b0, den, data, cor};
  endfunction

  function automatic logic [W-1:0] d_word();
    return {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_sink,
            tl.d_denied, tl.d_data, tl.d_corrupt};
  endfunction

  // Every D beat must match the oldest outstanding expected response.
  always @(negedge clock) begin
    if (!reset && tl.d_valid && tl.d_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp_extra: got %h expected no response", d_word());
      end else begin
        check("rsp", 64'(d_word()), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [2:0] param, input logic [1:0] size,
                      input logic [1:0] src, input logic [8:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input logic cor, input logic [W-1:0] exp_rsp);
    int waited = 0;
    tl.a_opcode  = op;
    tl.a_param   = param;
    tl.a_size    = size;
    tl.a_source  = src;
    tl.a_address = addr;
    tl.a_mask    = mask;
    tl.a_data    = data;
    tl.a_corrupt = cor;
    tl.a_valid   = 1'b1;
    while (!tl.a_ready && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    if (!tl.a_ready) begin
      check("a_ready_timeout", 64'(tl.a_ready), 64'd1);
      tl.a_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    tl.a_valid = 1'b0;
    exp_q.push_back(exp_rsp);
  endtask

  task automatic put2(input logic [1:0] src, input logic [8:0] addr, input logic [31:0] data);
    send(3'd0, 3'd0, 2'd2, src, addr, 4'hF, data, 1'b0, rsp(3'd0, 2'd2, src, 1'b0, 32'h0, 1'b0));
  endtask

  task automatic get2(input logic [1:0] src, input logic [8:0] addr, input logic [31:0] exp_data);
    send(3'd4, 3'd0, 2'd2, src, addr, 4'hF, 32'h0, 1'b0, rsp(3'd1, 2'd2, src, 1'b0, exp_data, 1'b0));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_idle", 64'(tl.d_valid), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tbl [3];
    tbl[0] = 32'h11111111;
    tbl[1] = 32'h22222222;
    tbl[2] = 32'h33333333;
    third_done   = 1'b0;
    reset        = 1'b1;
    tl.a_valid   = 1'b0;
    tl.a_opcode  = 3'd0;
    tl.a_param   = 3'd0;
    tl.a_size    = 2'd0;
    tl.a_source  = 2'd0;
    tl.a_address = 9'd0;
    tl.a_mask    = 4'h0;
    tl.a_data    = 32'h0;
    tl.a_corrupt = 1'b0;
    tl.d_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_d_valid", 64'(tl.d_valid), 64'd0);
    check("rst_a_ready", 64'(tl.a_ready), 64'd1);
    check("rst_d_fields", 64'(d_word()), 64'd0);
    tl.d_ready = 1'b1;

    // Basic write then read, one-cycle latency each.
    put2(2'd1, 9'h010, 32'hDEADBEEF);
    check("lat_put_valid", 64'(tl.d_valid), 64'd1);
    check("lat_put_source", 64'(tl.d_source), 64'd1);
    get2(2'd2, 9'h010, 32'hDEADBEEF);
    check("lat_get_valid", 64'(tl.d_valid), 64'd1);
    check("lat_get_data", 64'(tl.d_data), 64'hDEADBEEF);
    drain();

    // Partial write, then a poisoned write that must not land.
    send(3'd1, 3'd0, 2'd2, 2'd0, 9'h010, 4'b0100, 32'h00AA0000, 1'b0,
         rsp(3'd0, 2'd2, 2'd0, 1'b0, 32'h0, 1'b0));
    get2(2'd1, 9'h010, 32'hDEAABEEF);
    send(3'd0, 3'd0, 2'd2, 2'd2, 9'h010, 4'hF, 32'h01234567, 1'b1,
         rsp(3'd0, 2'd2, 2'd2, 1'b0, 32'h0, 1'b0));
    get2(2'd3, 9'h010, 32'hDEAABEEF);

    // Illegal requests, answered in order.
    send(3'd4, 3'd0, 2'd2, 2'd0, 9'h002, 4'hF, 32'h0, 1'b0,
         rsp(3'd1, 2'd2, 2'd0, 1'b1, 32'h0, 1'b1));
    send(3'd2, 3'd0, 2'd2, 2'd1, 9'h010, 4'hF, 32'hFFFFFFFF, 1'b0,
         rsp(3'd0, 2'd2, 2'd1, 1'b1, 32'h0, 1'b0));
    put2(2'd2, 9'h004, 32'h55667788);
    send(3'd0, 3'd0, 2'd1, 2'd3, 9'h004, 4'hF, 32'hFFFFFFFF, 1'b0,
         rsp(3'd0, 2'd1, 2'd3, 1'b1, 32'h0, 1'b0));
    get2(2'd0, 9'h004, 32'h55667788);
    // Legal byte write to lane 3, then a byte write with a lane outside em.
    send(3'd1, 3'd0, 2'd0, 2'd1, 9'h007, 4'b1000, 32'h99000000, 1'b0,
         rsp(3'd0, 2'd0, 2'd1, 1'b0, 32'h0, 1'b0));
    send(3'd1, 3'd0, 2'd0, 2'd2, 9'h005, 4'b0100, 32'h00EE0000, 1'b0,
         rsp(3'd0, 2'd0, 2'd2, 1'b1, 32'h0, 1'b0));
    // Non-zero param, size 3, misaligned half-word Get, legal half-word Get.
    send(3'd4, 3'd1, 2'd2, 2'd3, 9'h004, 4'hF, 32'h0, 1'b0,
         rsp(3'd1, 2'd2, 2'd3, 1'b1, 32'h0, 1'b1));
    send(3'd4, 3'd0, 2'd3, 2'd0, 9'h004, 4'hF, 32'h0, 1'b0,
         rsp(3'd1, 2'd3, 2'd0, 1'b1, 32'h0, 1'b1));
    send(3'd4, 3'd0, 2'd1, 2'd1, 9'h005, 4'b0110, 32'h0, 1'b0,
         rsp(3'd1, 2'd1, 2'd1, 1'b1, 32'h0, 1'b1));
    send(3'd4, 3'd0, 2'd1, 2'd2, 9'h006, 4'b1100, 32'h0, 1'b0,
         rsp(3'd1, 2'd1, 2'd2, 1'b0, 32'h99667788, 1'b0));
    drain();

    // Backpressure: two Gets fill the queue, the third stalls.
    put2(2'd0, 9'h020, tbl[0]);
    put2(2'd0, 9'h024, tbl[1]);
    put2(2'd0, 9'h028, tbl[2]);
    drain();
    tl.d_ready = 1'b0;
    get2(2'd0, 9'h020, tbl[0]);
    get2(2'd1, 9'h024, tbl[1]);
    fork
      begin
        get2(2'd2, 9'h028, tbl[2]);
        third_done = 1'b1;
      end
    join_none
    #1;
    check("full_a_ready", 64'(tl.a_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      check("stall_a_ready", 64'(tl.a_ready), 64'd0);
      check("stall_d_valid", 64'(tl.d_valid), 64'd1);
      check("stall_source", 64'(tl.d_source), 64'd0);
      check("stall_data", 64'(tl.d_data), 64'(tbl[0]));
    end
    tl.d_ready = 1'b1;
    for (int k = 0; k < 20 && !third_done; k++) begin
      @(posedge clock); #1;
    end
    check("third_accepted", 64'(third_done), 64'd1);
    drain();

    // Back-to-back Gets with simultaneous enqueue/dequeue at one entry.
    for (int i = 0; i < 20; i++) begin
      get2(2'(i), 9'h020 + 9'(4 * (i % 3)), tbl[i % 3]);
      check("b2b_d_valid", 64'(tl.d_valid), 64'd1);
      check("b2b_a_ready", 64'(tl.a_ready), 64'd1);
    end
    drain();

    // Reset with two responses queued: they vanish, RAM survives.
    tl.d_ready = 1'b0;
    get2(2'd1, 9'h020, tbl[0]);
    get2(2'd2, 9'h024, tbl[1]);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_d_valid", 64'(tl.d_valid), 64'd0);
    check("mid_rst_a_ready", 64'(tl.a_ready), 64'd1);
    check("mid_rst_d_fields", 64'(d_word()), 64'd0);
    tl.d_ready = 1'b1;
    get2(2'd3, 9'h010, 32'hDEAABEEF);
    drain();

    // A Put offered during reset must be ignored.
    reset        = 1'b1;
    tl.a_opcode  = 3'd0;
    tl.a_param   = 3'd0;
    tl.a_size    = 2'd2;
    tl.a_source  = 2'd1;
    tl.a_address = 9'h010;
    tl.a_mask    = 4'hF;
    tl.a_data    = 32'h12345678;
    tl.a_corrupt = 1'b0;
    tl.a_valid   = 1'b1;
    @(posedge clock); #1;
    reset      = 1'b0;
    tl.a_valid = 1'b0;
    check("rst_beat_dropped", 64'(tl.d_valid), 64'd0);
    get2(2'd0, 9'h010, 32'hDEAABEEF);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
